// File: rtl/x25519_pkg.sv
// Shared field constants, FSM encodings and GF(2^255-19) add/sub helpers.
package x25519_pkg;

    localparam int unsigned FE_W = 256;
    localparam int unsigned FOLD = 19;
    localparam int unsigned ST_W = 4;

    typedef logic [FE_W-1:0] fe_t;
    typedef logic [ST_W-1:0] state_t;

    localparam fe_t P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_LOAD  = 4'd1;
    localparam state_t S_AA    = 4'd2;
    localparam state_t S_BB    = 4'd3;
    localparam state_t S_DA    = 4'd4;
    localparam state_t S_CB    = 4'd5;
    localparam state_t S_X3SQ  = 4'd6;
    localparam state_t S_DSQ   = 4'd7;
    localparam state_t S_Z3X   = 4'd8;
    localparam state_t S_X2X   = 4'd9;
    localparam state_t S_A24E  = 4'd10;
    localparam state_t S_Z2X   = 4'd11;
    localparam state_t S_DONE  = 4'd12;

    // Bring any 256-bit value into [0,p); 2^256 < 3p so two subtracts suffice.
    function automatic fe_t fe_reduce(input fe_t x);
        fe_t r;
        r = x;
        if (r >= P) r = r - P;
        if (r >= P) r = r - P;
        return r;
    endfunction

    // Modular add of two reduced operands.
    function automatic fe_t fe_add(input fe_t a, input fe_t b);
        logic [FE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[FE_W-1:0];
    endfunction

    // Modular subtract of two reduced operands; borrow means add p back.
    function automatic fe_t fe_sub(input fe_t a, input fe_t b);
        logic [FE_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[FE_W]) d = d + {1'b0, P};
        return d[FE_W-1:0];
    endfunction

endpackage

// File: rtl/step_ladder_mul.sv
// Fixed-latency 256x256 modular multiplier: Karatsuba product, 2^255 = 19 folding.
module fe_mul
    import x25519_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FE_W-1:0] a,
    input  logic [FE_W-1:0] b,
    input  logic            start,
    output logic [FE_W-1:0] result,
    output logic            valid
);

    localparam int unsigned HW = FE_W / 2;

    logic [HW-1:0]        a0, a1, b0, b1;
    logic [HW:0]          sa, sb;
    logic [FE_W-1:0]      z0, z2;
    logic [FE_W+1:0]      zm, z1;
    logic [2*FE_W-1:0]    prod;
    logic [262:0]         t1;
    fe_t                  t2, t3, red;

    logic [MUL_LAT-1:0][FE_W-1:0] pipe_q;
    logic [MUL_LAT-1:0]           vld_q;

    // Product via one-level Karatsuba, then fold high part by 19 three times.
    always_comb begin
        a0   = a[HW-1:0];
        a1   = a[FE_W-1:HW];
        b0   = b[HW-1:0];
        b1   = b[FE_W-1:HW];
        sa   = (HW+1)'(a0) + (HW+1)'(a1);
        sb   = (HW+1)'(b0) + (HW+1)'(b1);
        z0   = FE_W'(a0) * FE_W'(b0);
        z2   = FE_W'(a1) * FE_W'(b1);
        zm   = (FE_W+2)'(sa) * (FE_W+2)'(sb);
        z1   = zm - (FE_W+2)'(z0) - (FE_W+2)'(z2);
        prod = {z2, z0} + ((2*FE_W)'(z1) << HW);
        t1   = 263'(prod[254:0]) + 263'(prod[511:255]) * 263'(FOLD);
        t2   = FE_W'(t1[254:0]) + FE_W'(t1[262:255]) * FE_W'(FOLD);
        t3   = FE_W'(t2[254:0]) + (t2[255] ? FE_W'(FOLD) : FE_W'(0));
        red  = (t3 >= P) ? (t3 - P) : t3;
    end

    if (MUL_LAT > 1) begin : g_multi
        // Delay line so the result appears MUL_LAT cycles after start.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_q <= '0;
                vld_q  <= '0;
            end else begin
                pipe_q <= {pipe_q[MUL_LAT-2:0], red};
                vld_q  <= {vld_q[MUL_LAT-2:0], start};
            end
        end
    end else begin : g_single
        // Single result register for one-cycle latency.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_q <= '0;
                vld_q  <= '0;
            end else begin
                pipe_q <= red;
                vld_q  <= start;
            end
        end
    end

    assign result = pipe_q[MUL_LAT-1];
    assign valid  = vld_q[MUL_LAT-1];

endmodule

// File: rtl/step_ladder.sv
// One X25519 Montgomery-ladder step: (X2:Z2),(X3:Z3),X1 -> doubled and sum points.
module step_ladder
    import x25519_pkg::*;
#(
    parameter int unsigned A24     = 121665,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FE_W-1:0] X1,
    input  logic [FE_W-1:0] X2,
    input  logic [FE_W-1:0] Z2,
    input  logic [FE_W-1:0] X3,
    input  logic [FE_W-1:0] Z3,
    output logic [FE_W-1:0] X2N,
    output logic [FE_W-1:0] Z2N,
    output logic [FE_W-1:0] X3N,
    output logic [FE_W-1:0] Z3N
);

    state_t state, state_nx;
    logic   busy;
    logic   mul_start_c;
    logic   mul_valid;
    fe_t    mul_a_c, mul_b_c, mul_res;

    fe_t x1_r, x2_r, z2_r, x3_r, z3_r;
    fe_t a_r, b_r, c_r, d_r;
    fe_t aa_r, bb_r, e_r, da_r, cb_r, sp_r, sm_r, dsq_r, t2_r;
    fe_t x2n_r, z2n_r, x3n_r, z3n_r;

    fe_mul #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .a      (mul_a_c),
        .b      (mul_b_c),
        .start  (mul_start_c),
        .result (mul_res),
        .valid  (mul_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state; each multiply state issues once and advances on its result.
    always_comb begin
        state_nx    = state;
        mul_start_c = 1'b0;
        case (state)
            S_IDLE: state_nx = S_LOAD;
            S_LOAD: state_nx = S_AA;
            S_AA, S_BB, S_DA, S_CB, S_X3SQ, S_DSQ, S_Z3X, S_X2X, S_A24E, S_Z2X: begin
                mul_start_c = !busy;
                if (mul_valid) state_nx = (state == S_Z2X) ? S_DONE : state + 4'd1;
            end
            S_DONE: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Multiplier operand selection for the current step.
    always_comb begin
        mul_a_c = '0;
        mul_b_c = '0;
        case (state)
            S_AA:   begin mul_a_c = a_r;         mul_b_c = a_r;   end
            S_BB:   begin mul_a_c = b_r;         mul_b_c = b_r;   end
            S_DA:   begin mul_a_c = d_r;         mul_b_c = a_r;   end
            S_CB:   begin mul_a_c = c_r;         mul_b_c = b_r;   end
            S_X3SQ: begin mul_a_c = sp_r;        mul_b_c = sp_r;  end
            S_DSQ:  begin mul_a_c = sm_r;        mul_b_c = sm_r;  end
            S_Z3X:  begin mul_a_c = x1_r;        mul_b_c = dsq_r; end
            S_X2X:  begin mul_a_c = aa_r;        mul_b_c = bb_r;  end
            S_A24E: begin mul_a_c = FE_W'(A24);  mul_b_c = e_r;   end
            S_Z2X:  begin mul_a_c = e_r;         mul_b_c = t2_r;  end
            default: ;
        endcase
    end

    // Tracks an in-flight multiply so each state issues exactly one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              busy <= 1'b0;
        else if (mul_start_c) busy <= 1'b1;
        else if (mul_valid)   busy <= 1'b0;
    end

    // Datapath: input capture, add/sub between multiplies, result publish in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_r  <= '0; x2_r  <= '0; z2_r  <= '0; x3_r  <= '0; z3_r <= '0;
            a_r   <= '0; b_r   <= '0; c_r   <= '0; d_r   <= '0;
            aa_r  <= '0; bb_r  <= '0; e_r   <= '0; da_r  <= '0; cb_r <= '0;
            sp_r  <= '0; sm_r  <= '0; dsq_r <= '0; t2_r  <= '0;
            x2n_r <= '0; z2n_r <= '0; x3n_r <= '0; z3n_r <= '0;
            X2N   <= '0; Z2N   <= '0; X3N   <= '0; Z3N   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    x1_r <= fe_reduce(X1);
                    x2_r <= fe_reduce(X2);
                    z2_r <= fe_reduce(Z2);
                    x3_r <= fe_reduce(X3);
                    z3_r <= fe_reduce(Z3);
                end
                S_LOAD: begin
                    a_r <= fe_add(x2_r, z2_r);
                    b_r <= fe_sub(x2_r, z2_r);
                    c_r <= fe_add(x3_r, z3_r);
                    d_r <= fe_sub(x3_r, z3_r);
                end
                S_DONE: begin
                    X2N <= x2n_r;
                    Z2N <= z2n_r;
                    X3N <= x3n_r;
                    Z3N <= z3n_r;
                end
                default: begin
                    if (mul_valid) begin
                        case (state)
                            S_AA:   aa_r <= mul_res;
                            S_BB: begin
                                bb_r <= mul_res;
                                e_r  <= fe_sub(aa_r, mul_res);
                            end
                            S_DA:   da_r <= mul_res;
                            S_CB: begin
                                cb_r <= mul_res;
                                sp_r <= fe_add(da_r, mul_res);
                                sm_r <= fe_sub(da_r, mul_res);
                            end
                            S_X3SQ: x3n_r <= mul_res;
                            S_DSQ:  dsq_r <= mul_res;
                            S_Z3X:  z3n_r <= mul_res;
                            S_X2X:  x2n_r <= mul_res;
                            S_A24E: t2_r  <= fe_add(aa_r, mul_res);
                            S_Z2X:  z2n_r <= mul_res;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_ladder.sv
// Directed and model-based checks for one ladder step, incl. latency and reset.
module tb_step_ladder;

    typedef logic [255:0] fv_t;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned L       = 2 + 10 * (MUL_LAT + 1);
    localparam fv_t PM = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fv_t  x1, x2, z2, x3, z3;
    fv_t  x2n, z2n, x3n, z3n;
    int   tests = 0;
    int   fails = 0;

    step_ladder #(.A24(121665), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .X1  (x1),
        .X2  (x2),
        .Z2  (z2),
        .X3  (x3),
        .Z3  (z3),
        .X2N (x2n),
        .Z2N (z2n),
        .X3N (x3n),
        .Z3N (z3n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input fv_t got, input fv_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic fv_t mmul(input fv_t a, input fv_t b);
        logic [511:0] pr;
        pr = 512'(a) * 512'(b);
        return 256'(pr % 512'(PM));
    endfunction

    function automatic fv_t madd(input fv_t a, input fv_t b);
        logic [256:0] s;
        s = 257'(a) + 257'(b);
        return 256'(s % 257'(PM));
    endfunction

    function automatic fv_t msub(input fv_t a, input fv_t b);
        return madd(a, PM - b);
    endfunction

    task automatic model(input fv_t ix1, input fv_t ix2, input fv_t iz2, input fv_t ix3, input fv_t iz3,
                         output fv_t ox2n, output fv_t oz2n, output fv_t ox3n, output fv_t oz3n);
        fv_t r1, r2, rz2, r3, rz3, a, b, c, d, aa, bb, e, da, cb;
        r1 = ix1 % PM; r2 = ix2 % PM; rz2 = iz2 % PM; r3 = ix3 % PM; rz3 = iz3 % PM;
        a  = madd(r2, rz2); b = msub(r2, rz2);
        c  = madd(r3, rz3); d = msub(r3, rz3);
        aa = mmul(a, a); bb = mmul(b, b); e = msub(aa, bb);
        da = mmul(d, a); cb = mmul(c, b);
        ox3n = mmul(madd(da, cb), madd(da, cb));
        oz3n = mmul(r1, mmul(msub(da, cb), msub(da, cb)));
        ox2n = mmul(aa, bb);
        oz2n = mmul(e, madd(aa, mmul(256'd121665, e)));
    endtask

    function automatic fv_t rnd_fe();
        fv_t r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r % PM;
    endfunction

    // Pulse reset, load inputs, check zero before edge L, result at L, and hold.
    task automatic run_step(input string tag,
                            input fv_t ix1, input fv_t ix2, input fv_t iz2, input fv_t ix3, input fv_t iz3,
                            input fv_t ex2n, input fv_t ez2n, input fv_t ex3n, input fv_t ez3n,
                            input int chg_at, input int hold);
        @(negedge clk);
        rst = 1'b1;
        x1 = ix1; x2 = ix2; z2 = iz2; x3 = ix3; z3 = iz3;
        @(negedge clk);
        rst = 1'b0;
        if (chg_at > 0) begin
            repeat (chg_at) @(posedge clk);
            @(negedge clk);
            x2 = ~ix2;
            repeat (int'(L) - chg_at) @(posedge clk);
        end else begin
            repeat (L) @(posedge clk);
        end
        @(negedge clk);
        check({tag, "_pre"}, x2n | z2n | x3n | z3n, '0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_x2n"}, x2n, ex2n);
        check({tag, "_z2n"}, z2n, ez2n);
        check({tag, "_x3n"}, x3n, ex3n);
        check({tag, "_z3n"}, z3n, ez3n);
        if (hold > 0) begin
            x1 = ~ix1; x2 = ~ix2; z2 = ~iz2; x3 = ~ix3; z3 = ~iz3;
            repeat (hold) @(negedge clk);
            check({tag, "_hold_x2n"}, x2n, ex2n);
            check({tag, "_hold_z2n"}, z2n, ez2n);
            check({tag, "_hold_x3n"}, x3n, ex3n);
            check({tag, "_hold_z3n"}, z3n, ez3n);
        end
    endtask

    fv_t r1, r2, r3, r4, r5, e1, e2, e3, e4;

    initial begin
        x1 = '0; x2 = '0; z2 = '0; x3 = '0; z3 = '0;
        #2;
        check("reset_out", x2n | z2n | x3n | z3n, '0);

        run_step("v1", 256'd3, 256'd15, 256'd2, 256'd36, 256'd9,
                 256'd48841, 256'd1752010680, 256'd1089936, 256'd47628, 0, 10);

        // Async clear from DONE: outputs drop without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_done", x2n | z2n | x3n | z3n, '0);

        run_step("v2", 256'd3, 256'd91, 256'd71, 256'd32, 256'd20,
                 256'd10497600, 256'd81262232609376, 256'd8904256, 256'd2451648, 0, 4);

        run_step("wrap", 256'd1, 256'd0, 256'd1, 256'd0, 256'd1,
                 256'd1, 256'd0, 256'd4, 256'd0, 0, 2);
        check("wrap_lt_p", 256'(x2n >= PM || z2n >= PM || x3n >= PM || z3n >= PM), '0);

        // Reset in the middle of a step, then a clean full run.
        @(negedge clk);
        rst = 1'b1;
        x1 = 256'd3; x2 = 256'd15; z2 = 256'd2; x3 = 256'd36; z3 = 256'd9;
        @(negedge clk);
        rst = 1'b0;
        repeat (L / 2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out", x2n | z2n | x3n | z3n, '0);
        run_step("v1_after_rst", 256'd3, 256'd15, 256'd2, 256'd36, 256'd9,
                 256'd48841, 256'd1752010680, 256'd1089936, 256'd47628, 0, 2);

        run_step("v1_chg", 256'd3, 256'd15, 256'd2, 256'd36, 256'd9,
                 256'd48841, 256'd1752010680, 256'd1089936, 256'd47628, 5, 0);

        // Out-of-range inputs still give reduced, congruent results.
        r1 = '1;
        model(r1, r1, r1, r1, r1, e1, e2, e3, e4);
        run_step("oob", r1, r1, r1, r1, r1, e1, e2, e3, e4, 0, 2);

        for (int n = 0; n < 1000; n++) begin
            r1 = rnd_fe(); r2 = rnd_fe(); r3 = rnd_fe(); r4 = rnd_fe(); r5 = rnd_fe();
            model(r1, r2, r3, r4, r5, e1, e2, e3, e4);
            run_step("rnd", r1, r2, r3, r4, r5, e1, e2, e3, e4, 0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/step_ladder.md
Name: step_ladder

Overview:
- One Montgomery-ladder step (differential add-and-double) for X25519 over GF(p), p = 2^255 - 19, per the RFC 7748 ladder formulas.
- Takes projective points (X2:Z2) and (X3:Z3) and base x-coordinate X1. Produces the doubled point (X2N:Z2N) and the sum (X3N:Z3N).
- The conditional swap (cswap) and the ladder loop are done by the parent controller. This block performs one step per reset release.

Parameters:
- A24, 121665, curve constant (A-2)/4 used in the Z2N formula.
- MUL_LAT, 4, latency in cycles of the internal modular multiplier; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset. Also serves as the start: a step begins when rst deasserts.
- X1  in  256  base-point x-coordinate, < p.
- X2  in  256  X of point 2, < p.
- Z2  in  256  Z of point 2, < p.
- X3  in  256  X of point 3, < p.
- Z3  in  256  Z of point 3, < p.
- X2N  out  256  doubled-point X, fully reduced.
- Z2N  out  256  doubled-point Z, fully reduced.
- X3N  out  256  sum-point X, fully reduced.
- Z3N  out  256  sum-point Z, fully reduced.
- Port order is exactly as listed.

Behaviour:
- Reset: while rst is high, all outputs and internal registers are 0 and the FSM is in IDLE. This applies asynchronously.
- Start: on the first rising clk edge with rst low, the FSM moves IDLE->LOAD and registers X1..Z3. Inputs need only be stable on that edge.
- Arithmetic, all mod p:
  - A = X2+Z2; B = X2-Z2; C = X3+Z3; D = X3-Z3.
  - AA = A^2; BB = B^2; E = AA-BB.
  - DA = D*A; CB = C*B.
  - X3N = (DA+CB)^2; Z3N = X1*(DA-CB)^2.
  - X2N = AA*BB; Z2N = E*(AA + A24*E).
- Add/sub: 257-bit intermediate, then one conditional correction (subtract p if sum >= p; add p if difference is negative). The result is always in [0,p).
- Multiplication:
  - One shared modular multiplier, one operation issued at a time.
  - Fixed latency MUL_LAT.
  - Produces a fully reduced result via 2^255 ≡ 19 folding plus final conditional subtract.
- FSM states: IDLE, LOAD, then ten MUL states in this fixed order: AA, BB, DA, CB, X3sq, Dsq, Z3x, X2x, A24E, Z2x. Then DONE. Add/sub updates happen in the cycle between multiplies.
- Latency: all four outputs update together, on the same edge, exactly L = 2 + 10*(MUL_LAT+1) cycles after the LOAD edge. With the default MUL_LAT, L = 52. Before that edge the outputs stay 0.
- DONE: outputs hold indefinitely. Input changes are ignored. A new step requires rst to be pulsed.
- Reset mid-operation: immediately clears all state and outputs. A partial result is never output.
- Inputs >= p are outside the contract. The result must still be congruent mod p and reduced.

Decomposition:
- Package x25519_pkg:
  - constants P (2^255-19) and FOLD (19);
  - typedef fe_t = logic [255:0];
  - FSM state enum.
- Sub-module fe_mul: pipelined/multi-cycle 256x256 modular multiplier, with Karatsuba-Ofman split recommended.
  - Ports: clk, rst, a, b, start, result, valid.
- Add/sub reduction is done as functions in x25519_pkg.

Test Plan:
- Vector 1: X1=3, X2=15, Z2=2, X3=36, Z3=9, rst low after 10 ns -> X2N=48841, Z2N=1752010680, X3N=1089936, Z3N=47628. Values appear at cycle L and hold.
- Vector 2, after a new rst pulse: X1=3, X2=91, Z2=71, X3=32, Z3=20 -> X2N=10497600, Z2N=81262232609376, X3N=8904256, Z3N=2451648.
- Wrap case: X2=0, Z2=1, X3=0, Z3=1, X1=1. B=D=p-1 must yield outputs matching a golden GF(p) model; check no value >= p.
- Reset mid-step: assert rst at cycle L/2 -> outputs 0 immediately. After release, a full L-cycle run gives correct vector-1 results.
- Input change after LOAD: change X2 at cycle 5 -> outputs still equal the vector-1 results.
- Random regression: 1000 random reduced inputs vs. a software RFC 7748 model. Check exact latency L and output stability in DONE.
